// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and multiply-latency bounds.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MUL_LATENCY_MIN = 1;
    localparam int MUL_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle of the multiply/divide unit; the unit sits on the
// slave modport, the issuing pipeline on the master modport.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, done_o, hi_o, lo_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, done_o, hi_o, lo_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider: one quotient bit per i_step, operands
// loaded by i_start; o_last flags the step that produces the final bit.
module muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_last
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // The partial remainder stays below the divisor, so bit WIDTH of the
    // trial difference is a reliable "would go negative" flag.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_diff[WIDTH]) begin
                r_rem  <= w_diff[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit with IDLE/MUL/DIV/FIX sequencing.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W    = $clog2(MUL_LATENCY_MAX);
    localparam int MUL_WAIT = (MUL_LATENCY > MUL_LATENCY_MIN) ? MUL_LATENCY - 2 : 0;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_signed;
    logic [CNT_W-1:0]   r_mul_cnt;
    logic               r_done;
    logic               w_accept;
    logic [WIDTH-1:0]   w_mul_a;
    logic [WIDTH-1:0]   w_mul_b;
    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = (r_state == ST_IDLE) && bus.start_i && !bus.flush_i;

    // A single-cycle multiply completes on the accept edge, so it must see
    // the live operands rather than the latched copies.
    assign w_mul_a      = (MUL_LATENCY == 1) ? bus.a_i : r_a;
    assign w_mul_b      = (MUL_LATENCY == 1) ? bus.b_i : r_b;
    assign w_mul_signed = (MUL_LATENCY == 1) ? (bus.op_i == OP_MULT) : r_signed;
    assign w_ext_a      = {{WIDTH{w_mul_signed & w_mul_a[WIDTH-1]}}, w_mul_a};
    assign w_ext_b      = {{WIDTH{w_mul_signed & w_mul_b[WIDTH-1]}}, w_mul_b};
    assign w_prod       = w_ext_a * w_ext_b;

`ifdef MULDIV_DIV_EN
    logic             r_dz;
    logic             w_op_sdiv;
    logic             w_div_start;
    logic             w_div_last;
    logic             w_div_zero;
    logic             w_q_neg;
    logic             w_r_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_op_sdiv   = (bus.op_i == OP_DIV);
    assign w_div_start = w_accept && ((bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU));
    assign w_abs_a     = (w_op_sdiv && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign w_abs_b     = (w_op_sdiv && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
    assign w_div_zero  = (r_b == '0);
    assign w_q_neg     = r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg     = r_signed && r_a[WIDTH-1];

    muldiv_divider #(.WIDTH(WIDTH)) u_divider (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_step     (r_state == ST_DIV),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_div_last)
    );

    assign bus.div_zero_o = r_dz;
`else
    assign bus.div_zero_o = 1'b0;
`endif

    // NOTE: all state here is written with <= so every register samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_signed  <= 1'b0;
            r_mul_cnt <= '0;
            r_done    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_dz      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_dz   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a      <= bus.a_i;
                        r_b      <= bus.b_i;
                        r_signed <= (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
                        case (bus.op_i)
                            OP_MULT, OP_MULTU: begin
                                if (MUL_LATENCY == 1) begin
                                    {r_hi, r_lo} <= w_prod;
                                    r_done       <= 1'b1;
                                end else begin
                                    r_state   <= ST_MUL;
                                    r_mul_cnt <= CNT_W'(MUL_WAIT);
                                end
                            end
`ifdef MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: r_state <= ST_DIV;
`endif
                            OP_MTHI: begin
                                r_hi   <= bus.a_i;
                                r_done <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo   <= bus.a_i;
                                r_done <= 1'b1;
                            end
                            default: r_done <= 1'b1;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (bus.flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_mul_cnt == '0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 1'b1;
                    end
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    if (bus.flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_div_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    if (!bus.flush_i) begin
                        r_done <= 1'b1;
                        r_dz   <= w_div_zero;
                        if (w_div_zero) begin
                            r_lo <= '1;
                            r_hi <= r_a;
                        end else begin
                            r_lo <= w_q_neg ? -w_quot : w_quot;
                            r_hi <= w_r_neg ? -w_rem  : w_rem;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o = (r_state != ST_IDLE);
    assign bus.done_o = r_done;
    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic HI/LO model (divide expectations follow MULDIV_DIV_EN).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;
`ifdef MULDIV_DIV_EN
    localparam int DIV_LAT = W + 2;
`else
    localparam int DIV_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_LATENCY(MUL_LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected HI/LO, flag and accept-to-done latency from plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dz, output int lat);
        logic [63:0] p;
        longint      sa, sb, q, r;
        hi  = m_hi;
        lo  = m_lo;
        dz  = 1'b0;
        lat = 1;
        case (op)
            OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
                {hi, lo} = p;
                lat = MUL_LAT;
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {hi, lo} = p;
                lat = MUL_LAT;
            end
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
                lat = DIV_LAT;
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                    dz = 1'b1;
                end else if (op == OP_DIV) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[W-1:0];
                    hi = r[W-1:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
`endif
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] e_hi, e_lo;
        logic         e_dz;
        int           e_lat;
        int           lat;
        model(op, a, b, e_hi, e_lo, e_dz, e_lat);
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.op_i    = 3'($urandom);
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        check({tag, " busy"}, 64'(bus.busy_o), 64'(e_lat > 1));
        lat = 1;
        while (!bus.done_o && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " hi"}, 64'(bus.hi_o), 64'(e_hi));
        check({tag, " lo"}, 64'(bus.lo_o), 64'(e_lo));
        check({tag, " div_zero"}, 64'(bus.div_zero_o), 64'(e_dz));
        check({tag, " busy at done"}, 64'(bus.busy_o), 64'(0));
        tick();
        check({tag, " done drop"}, 64'(bus.done_o), 64'(0));
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset hi", 64'(bus.hi_o), 64'(0));
        check("reset lo", 64'(bus.lo_o), 64'(0));
        check("reset busy", 64'(bus.busy_o), 64'(0));
        check("reset done", 64'(bus.done_o), 64'(0));
        check("reset div_zero", 64'(bus.div_zero_o), 64'(0));
        rst = 1'b1;

        // First accept on the first edge after reset release.
        run_op("mtlo first", OP_MTLO, 32'h0000_1234, 32'h0);
        run_op("mthi", OP_MTHI, 32'hCAFE_F00D, 32'h0);
        run_op("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult -2*3 hi const", 64'(bus.hi_o), 64'(32'hFFFF_FFFF));
        check("mult -2*3 lo const", 64'(bus.lo_o), 64'(32'hFFFF_FFFA));
        run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu hi const", 64'(bus.hi_o), 64'(32'hFFFF_FFFE));
        check("multu lo const", 64'(bus.lo_o), 64'(32'h0000_0001));
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0);
        run_op("div 9/3", OP_DIV, 32'd9, 32'd3);
        run_op("divu big", OP_DIVU, 32'hF000_0001, 32'd7);
        run_op("undef op6", 3'd6, 32'h1111_1111, 32'h2);
        run_op("undef op7", 3'd7, 32'h3333_3333, 32'h4);

        // Flush on the completing multiply cycle suppresses the write.
        bus.op_i = OP_MULT; bus.a_i = 32'd123; bus.b_i = 32'd456; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (MUL_LAT - 2) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("mul flush done", 64'(bus.done_o), 64'(0));
        check("mul flush busy", 64'(bus.busy_o), 64'(0));
        check("mul flush hi", 64'(bus.hi_o), 64'(m_hi));
        check("mul flush lo", 64'(bus.lo_o), 64'(m_lo));

`ifdef MULDIV_DIV_EN
        // Flush a divide at cycle 10; nothing may complete afterwards.
        bus.op_i = OP_DIV; bus.a_i = 32'd1000; bus.b_i = 32'd7; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (9) tick();
        check("div flush busy before", 64'(bus.busy_o), 64'(1));
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("div flush busy after", 64'(bus.busy_o), 64'(0));
        dones = 0;
        repeat (40) begin
            if (bus.done_o) dones++;
            tick();
        end
        check("div flush no done", 64'(dones), 64'(0));
        check("div flush hi", 64'(bus.hi_o), 64'(m_hi));
        check("div flush lo", 64'(bus.lo_o), 64'(m_lo));
`endif

        // A start while busy is dropped, not queued.
        bus.op_i = OP_MULTU; bus.a_i = 32'd5; bus.b_i = 32'd7; bus.start_i = 1'b1;
        tick();
        bus.op_i = OP_MTLO; bus.a_i = 32'hDEAD_BEEF;
        check("busy ignore busy", 64'(bus.busy_o), 64'(1));
        repeat (MUL_LAT - 1) tick();
        bus.start_i = 1'b0;
        check("busy ignore done", 64'(bus.done_o), 64'(1));
        check("busy ignore product", 64'({bus.hi_o, bus.lo_o}), 64'd35);
        tick();
        check("busy ignore not queued lo", 64'(bus.lo_o), 64'd35);
        check("busy ignore not queued done", 64'(bus.done_o), 64'(0));
        m_hi = 32'd0;
        m_lo = 32'd35;

        // Flush together with start in IDLE: nothing is accepted.
        bus.op_i = OP_MTLO; bus.a_i = 32'h5555_5555; bus.start_i = 1'b1; bus.flush_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        check("flush+start done", 64'(bus.done_o), 64'(0));
        check("flush+start busy", 64'(bus.busy_o), 64'(0));
        check("flush+start lo", 64'(bus.lo_o), 64'(m_lo));

        // Asynchronous reset in the middle of an operation.
        run_op("pre-reset mthi", OP_MTHI, 32'hA5A5_0001, 32'h0);
`ifdef MULDIV_DIV_EN
        bus.op_i = OP_DIV;
`else
        bus.op_i = OP_MULT;
`endif
        bus.a_i = 32'd77; bus.b_i = 32'd3; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("mid-op busy", 64'(bus.busy_o), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("async reset hi", 64'(bus.hi_o), 64'(0));
        check("async reset lo", 64'(bus.lo_o), 64'(0));
        check("async reset busy", 64'(bus.busy_o), 64'(0));
        check("async reset done", 64'(bus.done_o), 64'(0));
        tick();
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        run_op("mtlo after reset", OP_MTLO, 32'h0000_1234, 32'h0);

        for (int i = 0; i < 80; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width, even, at least 8.
REQ-002 SHALL have parameter MUL_LATENCY, default 2: multiply cycles from accept to done, range 1..4.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: request valid.
REQ-006 SHALL have port op_i, input, 3 bits: operation select (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-007 SHALL have ports a_i and b_i, input, WIDTH bits each: operands, where a_i is the dividend or MTHI/MTLO source.
REQ-008 SHALL have port flush_i, input, 1 bit: abort any in-flight operation.
REQ-009 SHALL have port busy_o, output, 1 bit: operation in flight; new starts are ignored.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle pulse on the cycle HI/LO first show the new result.
REQ-011 SHALL have ports hi_o and lo_o, output, WIDTH bits each: architectural HI/LO registers.
REQ-012 SHALL have port div_zero_o, output, 1 bit: pulses with done_o when a divide had divisor 0.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX. Start is accepted only in IDLE with start_i=1 and flush_i=0.
REQ-014 MULT/MULTU: IDLE->MUL. {hi,lo} SHALL get the full 2*WIDTH product (signed or unsigned) MUL_LATENCY cycles after accept. done_o pulses that cycle, then IDLE.
REQ-015 DIV/DIVU: IDLE->DIV for WIDTH iterations (restoring, one quotient bit per cycle), then FIX for sign correction. done_o SHALL pulse WIDTH+2 cycles after accept. lo = quotient, hi = remainder.
REQ-016 Signed divide SHALL truncate toward zero; remainder sign SHALL follow the dividend.
REQ-017 Divisor 0: lo = all ones, hi = a_i, div_zero_o=1 with done_o, still WIDTH+2 cycles.
REQ-018 Signed MIN / -1: lo = MIN, hi = 0, no flag.
REQ-019 MTHI/MTLO: the selected register SHALL load a_i on the accept edge, the other register is unchanged, busy_o stays 0, and done_o pulses in the following cycle.
REQ-020 busy_o SHALL be 1 in MUL, DIV and FIX, and 0 in IDLE (including the done cycle).
REQ-021 start_i while busy_o=1 SHALL be ignored, with no queuing.
REQ-022 flush_i=1 in any non-IDLE state SHALL return to IDLE on the next edge. HI/LO are unchanged and done_o and div_zero_o are not pulsed.
REQ-023 flush_i on the completing cycle SHALL suppress the HI/LO write.
REQ-024 flush_i together with start_i in IDLE: flush wins and nothing is accepted.
REQ-025 Operands SHALL be latched at accept; later a_i/b_i changes have no effect.
REQ-026 Undefined op_i codes SHALL be accepted as no-ops: done_o pulses next cycle, HI/LO are unchanged.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, hi_o=lo_o=0, and busy_o=done_o=div_zero_o=0, including mid-operation; the partial result is discarded.
REQ-028 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: divide support is present as specified above.
REQ-030 Macro MULDIV_DIV_EN undefined: no divider logic; DIV/DIVU behave as REQ-026 no-ops and div_zero_o is tied 0.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold the op_i encodings, the state enum, and the MUL_LATENCY bounds.
REQ-032 Sub-module muldiv_divider SHALL implement the iterative unsigned restoring core. Sign handling, FIX and HI/LO stay in muldiv_unit.

Verification
REQ-033 MULT with a=0xFFFFFFFE (-2), b=3 -> after 2 cycles done_o; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV with a=-7, b=2 -> done_o at cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero_o=1.
REQ-036 DIV started, flush_i at cycle 10 -> busy_o=0 next cycle, HI/LO keep prior values, no done_o. A start_i during busy -> ignored.
REQ-037 rst pulsed low mid-DIV -> hi_o=lo_o=0 immediately. MTLO a=0x1234 right after release -> lo=0x1234, done_o the next cycle.
REQ-038 Build without MULDIV_DIV_EN: DIV with a=9, b=3 -> done_o after 1 cycle, HI/LO unchanged.
